// File: rtl/e203_ifu_flush_rsp.sv
// IFU flush responder: accepts a pipeline flush, drains stale fetch responses,
// then issues the redirect PC. Build macro E203_IFU_FLUSH_PC_DIRECT_EN selects the precomputed target.
module e203_ifu_flush_rsp #(
   parameter int E203_PC_SIZE = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pipe_flush_req,
   input  logic [E203_PC_SIZE-1:0] pipe_flush_add_op1,
   input  logic [E203_PC_SIZE-1:0] pipe_flush_add_op2,
   input  logic [E203_PC_SIZE-1:0] pipe_flush_pc,
   output logic                    pipe_flush_ack,
   input  logic                    ifu_req_hsked,
   input  logic                    ifu_rsp_hsked,
   output logic                    fetch_halt,
   output logic                    rsp_discard,
   output logic                    flush_pc_vld,
   output logic [E203_PC_SIZE-1:0] flush_pc,
   input  logic                    flush_pc_rdy,
   output logic [1:0]              dbg_state_o,
   output logic [1:0]              dbg_cnt_o
);

   // Handshake rule: a redirect transfers on a cycle where flush_pc_vld and
   // flush_pc_rdy are both high; flush_pc holds steady while vld waits for rdy.
   // dbg_state_o encoding: 0 = IDLE, 1 = DRAIN, 2 = ISSUE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ISSUE = 2'd2
   } state_e;

   state_e                  state_q;
   logic [1:0]              cnt_q, cnt_d;
   logic [E203_PC_SIZE-1:0] flush_pc_q, target_d;
   logic                    halt_q, discard_q, vld_q;
   logic                    ack;

   always_comb begin
      cnt_d = cnt_q;
      if (ifu_req_hsked && !ifu_rsp_hsked && (cnt_q != 2'd2)) begin
         cnt_d = cnt_q + 2'd1;
      end else if (ifu_rsp_hsked && !ifu_req_hsked && (cnt_q != 2'd0)) begin
         cnt_d = cnt_q - 2'd1;
      end
   end

`ifdef E203_IFU_FLUSH_PC_DIRECT_EN
   logic unused_add_ops;
   assign unused_add_ops = ^{pipe_flush_add_op1, pipe_flush_add_op2};
   assign target_d       = pipe_flush_pc;
`else
   logic unused_direct_pc;
   assign unused_direct_pc = ^pipe_flush_pc;
   // Carry out of the top bit is dropped: the target wraps modulo 2^E203_PC_SIZE.
   assign target_d         = pipe_flush_add_op1 + pipe_flush_add_op2;
`endif

   // Ack is gated by rst_n so it stays low for the whole reset assertion.
   assign ack = rst_n && (state_q == ST_IDLE) && pipe_flush_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 2'd0;
         flush_pc_q <= '0;
         halt_q     <= 1'b0;
         discard_q  <= 1'b0;
         vld_q      <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            ST_IDLE: begin
               if (ack) begin
                  flush_pc_q <= target_d;
                  halt_q     <= 1'b1;
                  if (cnt_d != 2'd0) begin
                     state_q   <= ST_DRAIN;
                     discard_q <= 1'b1;
                     vld_q     <= 1'b0;
                  end else begin
                     state_q   <= ST_ISSUE;
                     discard_q <= 1'b0;
                     vld_q     <= 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (cnt_d == 2'd0) begin
                  state_q   <= ST_ISSUE;
                  discard_q <= 1'b0;
                  vld_q     <= 1'b1;
               end
            end
            ST_ISSUE: begin
               if (vld_q && flush_pc_rdy) begin
                  state_q <= ST_IDLE;
                  halt_q  <= 1'b0;
                  vld_q   <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               halt_q    <= 1'b0;
               discard_q <= 1'b0;
               vld_q     <= 1'b0;
            end
         endcase
      end
   end

   assign pipe_flush_ack = ack;
   assign fetch_halt     = halt_q;
   assign rsp_discard    = discard_q;
   assign flush_pc_vld   = vld_q;
   assign flush_pc       = flush_pc_q;
   assign dbg_state_o    = state_q;
   assign dbg_cnt_o      = cnt_q;

endmodule

// File: tb/tb_e203_ifu_flush_rsp.sv
// Directed bench for e203_ifu_flush_rsp: cycle table plus reset corner sequences.
module tb_e203_ifu_flush_rsp;

   localparam bit DIRECT =
`ifdef E203_IFU_FLUSH_PC_DIRECT_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        pipe_flush_req;
   logic [31:0] op1, op2, fpc_in;
   logic        pipe_flush_ack;
   logic        ifu_req_hsked, ifu_rsp_hsked;
   logic        fetch_halt, rsp_discard, flush_pc_vld;
   logic [31:0] flush_pc;
   logic        flush_pc_rdy;
   logic [1:0]  dbg_state, dbg_cnt;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];

   e203_ifu_flush_rsp #(.E203_PC_SIZE(32)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .pipe_flush_req     (pipe_flush_req),
      .pipe_flush_add_op1 (op1),
      .pipe_flush_add_op2 (op2),
      .pipe_flush_pc      (fpc_in),
      .pipe_flush_ack     (pipe_flush_ack),
      .ifu_req_hsked      (ifu_req_hsked),
      .ifu_rsp_hsked      (ifu_rsp_hsked),
      .fetch_halt         (fetch_halt),
      .rsp_discard        (rsp_discard),
      .flush_pc_vld       (flush_pc_vld),
      .flush_pc           (flush_pc),
      .flush_pc_rdy       (flush_pc_rdy),
      .dbg_state_o        (dbg_state),
      .dbg_cnt_o          (dbg_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic [31:0] op1, op2, pc;
      logic        rqh, rsh, rdy;
      logic        ack, halt, disc, vld;
      logic [31:0] fpc;
      logic [1:0]  st, cnt;
   } vec_t;

   vec_t vt[18];

   function automatic logic [31:0] tgt(logic [31:0] sum_v, logic [31:0] pc_v);
      return DIRECT ? pc_v : sum_v;
   endfunction

   function automatic vec_t mk(logic req, logic [31:0] a, logic [31:0] b, logic [31:0] p,
                               logic rqh, logic rsh, logic rdy,
                               logic ack, logic halt, logic disc, logic vld,
                               logic [31:0] fpc, logic [1:0] st, logic [1:0] cnt);
      vec_t v;
      v.req = req; v.op1 = a; v.op2 = b; v.pc = p;
      v.rqh = rqh; v.rsh = rsh; v.rdy = rdy;
      v.ack = ack; v.halt = halt; v.disc = disc; v.vld = vld;
      v.fpc = fpc; v.st = st; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s row=%0d got=%h want=%h", name, row, got, want);
      end
   endtask

   task automatic drive(input vec_t v);
      pipe_flush_req = v.req;
      op1            = v.op1;
      op2            = v.op2;
      fpc_in         = v.pc;
      ifu_req_hsked  = v.rqh;
      ifu_rsp_hsked  = v.rsh;
      flush_pc_rdy   = v.rdy;
   endtask

   task automatic check_row(input int i, input vec_t v);
      chk("ack",   i, {31'd0, pipe_flush_ack}, {31'd0, v.ack});
      chk("halt",  i, {31'd0, fetch_halt},     {31'd0, v.halt});
      chk("disc",  i, {31'd0, rsp_discard},    {31'd0, v.disc});
      chk("vld",   i, {31'd0, flush_pc_vld},   {31'd0, v.vld});
      chk("pc",    i, flush_pc,                v.fpc);
      chk("state", i, {30'd0, dbg_state},      {30'd0, v.st});
      chk("cnt",   i, {30'd0, dbg_cnt},        {30'd0, v.cnt});
   endtask

   initial begin
      logic [31:0] ta, tb_, tc;
      ta  = tgt(32'h8000_0010, 32'h2000_0100);
      tb_ = tgt(32'h0000_0004, 32'h2000_0200);
      tc  = tgt(32'h0000_1200, 32'h3000_0000);
      exp_q.push_back(ta);
      exp_q.push_back(tb_);

      //        req op1            op2            pc             rqh rsh rdy ack hlt dsc vld fpc    st cnt
      vt[0]  = mk(0, 32'h0,         32'h0,         32'h0,         0,  0,  0,  0,  0,  0,  0,  32'h0, 0, 0);
      vt[1]  = mk(1, 32'h8000_0000, 32'h0000_0010, 32'h2000_0100, 0,  0,  0,  1,  0,  0,  0,  32'h0, 0, 0);
      vt[2]  = mk(0, 32'h0,         32'h0,         32'h0,         0,  0,  1,  0,  1,  0,  1,  ta,    2, 0);
      vt[3]  = mk(0, 32'h0,         32'h0,         32'h0,         0,  1,  0,  0,  0,  0,  0,  ta,    0, 0);
      vt[4]  = mk(0, 32'h0,         32'h0,         32'h0,         1,  0,  0,  0,  0,  0,  0,  ta,    0, 0);
      vt[5]  = mk(0, 32'h0,         32'h0,         32'h0,         1,  0,  0,  0,  0,  0,  0,  ta,    0, 1);
      vt[6]  = mk(0, 32'h0,         32'h0,         32'h0,         1,  0,  0,  0,  0,  0,  0,  ta,    0, 2);
      vt[7]  = mk(1, 32'hFFFF_FFFC, 32'h0000_0008, 32'h2000_0200, 0,  0,  0,  1,  0,  0,  0,  ta,    0, 2);
      vt[8]  = mk(1, 32'hFFFF_FFFC, 32'h0000_0008, 32'h2000_0200, 0,  0,  0,  0,  1,  1,  0,  tb_,   1, 2);
      vt[9]  = mk(1, 32'hFFFF_FFFC, 32'h0000_0008, 32'h2000_0200, 0,  1,  0,  0,  1,  1,  0,  tb_,   1, 2);
      vt[10] = mk(1, 32'hFFFF_FFFC, 32'h0000_0008, 32'h2000_0200, 1,  1,  0,  0,  1,  1,  0,  tb_,   1, 1);
      vt[11] = mk(1, 32'hFFFF_FFFC, 32'h0000_0008, 32'h2000_0200, 0,  0,  0,  0,  1,  1,  0,  tb_,   1, 1);
      vt[12] = mk(1, 32'hFFFF_FFFC, 32'h0000_0008, 32'h2000_0200, 0,  1,  0,  0,  1,  1,  0,  tb_,   1, 1);
      vt[13] = mk(1, 32'h0,         32'h0,         32'h0,         0,  0,  0,  0,  1,  0,  1,  tb_,   2, 0);
      vt[14] = mk(1, 32'h0000_1234, 32'h0000_0001, 32'h0,         0,  0,  0,  0,  1,  0,  1,  tb_,   2, 0);
      vt[15] = mk(1, 32'h0000_1234, 32'h0000_0001, 32'h0,         0,  0,  1,  0,  1,  0,  1,  tb_,   2, 0);
      vt[16] = mk(1, 32'h0000_1000, 32'h0000_0200, 32'h3000_0000, 0,  0,  0,  1,  0,  0,  0,  tb_,   0, 0);
      vt[17] = mk(0, 32'h0,         32'h0,         32'h0,         0,  0,  0,  0,  1,  0,  1,  tc,    2, 0);

      // reset with a pending request: nothing may respond
      rst_n = 1'b0;
      drive(mk(1, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
      #3;
      chk("rst_ack",  -1, {31'd0, pipe_flush_ack}, 32'd0);
      chk("rst_halt", -1, {31'd0, fetch_halt},     32'd0);
      chk("rst_vld",  -1, {31'd0, flush_pc_vld},   32'd0);
      chk("rst_pc",   -1, flush_pc,                32'd0);
      @(negedge clk);
      rst_n          = 1'b1;
      pipe_flush_req = 1'b0;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(vt[i]);
         #1;
         check_row(i, vt[i]);
         if (flush_pc_vld && flush_pc_rdy) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL redirect_extra row=%0d got=%h want=none", i, flush_pc);
            end else begin
               chk("redirect", i, flush_pc, exp_q.pop_front());
            end
         end
      end
      chk("redirects_left", 99, exp_q.size(), 32'd0);

      // asynchronous reset while issuing a redirect
      @(negedge clk);
      drive(mk(1, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
      #1;
      chk("pre_rst_vld", 100, {31'd0, flush_pc_vld}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ack",   101, {31'd0, pipe_flush_ack}, 32'd0);
      chk("arst_halt",  101, {31'd0, fetch_halt},     32'd0);
      chk("arst_disc",  101, {31'd0, rsp_discard},    32'd0);
      chk("arst_vld",   101, {31'd0, flush_pc_vld},   32'd0);
      chk("arst_pc",    101, flush_pc,                32'd0);
      chk("arst_state", 101, {30'd0, dbg_state},      32'd0);
      chk("arst_cnt",   101, {30'd0, dbg_cnt},        32'd0);
      @(negedge clk);
      #1;
      chk("hold_ack", 102, {31'd0, pipe_flush_ack}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_state", 103, {30'd0, dbg_state},      32'd0);
      chk("rel_ack",   103, {31'd0, pipe_flush_ack}, 32'd1);
      chk("rel_halt",  103, {31'd0, fetch_halt},     32'd0);
      @(negedge clk);
      pipe_flush_req = 1'b0;
      flush_pc_rdy   = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/e203_ifu_flush_rsp.md
E203_IFU_FLUSH_RSP -- requirements
Module: e203_ifu_flush_rsp

Interface
REQ-001 SHALL provide clk  input  1  core clock; all flops rise-edge.
REQ-002 SHALL provide rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL provide pipe_flush_req  input  1  flush request from commit; held high until acked.
REQ-004 SHALL provide pipe_flush_add_op1  input  E203_PC_SIZE  flush target adder operand 1.
REQ-005 SHALL provide pipe_flush_add_op2  input  E203_PC_SIZE  flush target adder operand 2.
REQ-006 SHALL provide pipe_flush_pc  input  E203_PC_SIZE  precomputed flush target; used only under REQ-025.
REQ-007 SHALL provide pipe_flush_ack  output  1  flush accepted this cycle.
REQ-008 SHALL provide ifu_req_hsked  input  1  fetch request handshake to memory this cycle.
REQ-009 SHALL provide ifu_rsp_hsked  input  1  fetch response handshake this cycle.
REQ-010 SHALL provide fetch_halt  output  1  block new fetch requests.
REQ-011 SHALL provide rsp_discard  output  1  drop the fetch response (stale, pre-flush).
REQ-012 SHALL provide flush_pc_vld  output  1  redirect target valid to fetch-request generator.
REQ-013 SHALL provide flush_pc  output  E203_PC_SIZE  redirect target.
REQ-014 SHALL provide flush_pc_rdy  input  1  fetch-request generator accepts redirect.

Function
REQ-015 SHALL keep a 2-bit outstanding counter: +1 on ifu_req_hsked only, -1 on ifu_rsp_hsked only, unchanged when both or neither; saturate at 2 (further increment ignored) and at 0 (decrement ignored).
REQ-016 SHALL implement states IDLE, DRAIN, ISSUE, encoded in flops.
REQ-017 In IDLE, pipe_flush_ack SHALL equal pipe_flush_req combinationally; pipe_flush_ack SHALL be 0 in DRAIN and ISSUE.
REQ-018 On ack, the target SHALL be registered into flush_pc: op1+op2 modulo 2^E203_PC_SIZE, carry discarded, no bit masking.
REQ-019 On ack: next state DRAIN if next-cycle counter value is nonzero, else ISSUE.
REQ-020 DRAIN SHALL assert rsp_discard; transition to ISSUE in the cycle after the counter reaches 0 (a response handshake bringing it 1->0 moves to ISSUE next cycle).
REQ-021 ISSUE SHALL assert flush_pc_vld; flush_pc stable until flush_pc_rdy; on flush_pc_vld & flush_pc_rdy go IDLE.
REQ-022 fetch_halt SHALL be 1 in DRAIN and ISSUE, 0 in IDLE; flush latency ack-to-flush_pc_vld = 1 cycle + drain time.
REQ-023 A pipe_flush_req arriving in DRAIN/ISSUE SHALL wait unacked; it is acked in IDLE no earlier than the cycle after the ISSUE handshake.

Reset
REQ-024 On rst_n low: state IDLE, counter 0, flush_pc 0; pipe_flush_ack follows pipe_flush_req only after reset released; fetch_halt, rsp_discard, flush_pc_vld 0; reset mid-DRAIN/ISSUE abandons the flush.

Configuration
REQ-025 Macro E203_IFU_FLUSH_PC_DIRECT_EN: defined -> flush_pc registered from pipe_flush_pc, no adder instantiated, add_op inputs unused; undefined -> adder per REQ-018, pipe_flush_pc unused.

Verification
REQ-026 Counter 0, req with op1=0x8000_0000 op2=0x0000_0010 -> ack same cycle, next cycle flush_pc_vld=1 flush_pc=0x8000_0010, fetch_halt=1; rdy=1 -> IDLE next cycle.
REQ-027 Counter 2, req acked -> DRAIN, rsp_discard=1 for two response handshakes, ISSUE the cycle after second; no ack for a new req until IDLE.
REQ-028 op1=0xFFFF_FFFC op2=0x0000_0008 -> flush_pc=0x0000_0004 (wrap).
REQ-029 Counter 1, same-cycle req_hsked and rsp_hsked during DRAIN -> counter stays 1, remains DRAIN.
REQ-030 rst_n dropped while in ISSUE with flush_pc_vld=1 -> all outputs 0 asynchronously, state IDLE after release.
REQ-031 With E203_IFU_FLUSH_PC_DIRECT_EN, pipe_flush_pc=0x2000_0100, ops arbitrary -> flush_pc=0x2000_0100.
